// File: rtl/hk_flash_passthru_ctrl.sv
// rtl/hk_flash_passthru_ctrl.sv - SCK-domain housekeeping SPI pass-through to mgmt/user flash
// Routes SPI to the locked flash target and truncates write-protected enable commands to 7 bits.
module hk_flash_passthru_ctrl #(
  parameter logic [6:0] WP_PREFIX0 = 7'b0000011,
  parameter logic [6:0] WP_PREFIX1 = 7'b0101000
) (
  input  logic       SCK,
  input  logic       csb_reset,
  input  logic       SDI,
  input  logic       slave_sdo,
  output logic       SDO,
  input  logic       pt_mgmt_sel,
  input  logic       pt_user_sel,
  input  logic       wp_mgmt,
  input  logic       wp_user,
  output logic       mgmt_flash_csb,
  output logic       user_flash_csb,
  output logic       mgmt_flash_clk,
  output logic       user_flash_clk,
  output logic       mgmt_flash_io0,
  output logic       user_flash_io0,
  input  logic       mgmt_flash_io1,
  input  logic       user_flash_io1,
  output logic       active,
  output logic [7:0] cmd_byte,
  output logic [7:0] byte_cnt,
  output logic       wp_block
);

  logic       sel_mgmt_q;
  logic       sel_user_q;
  logic       killed;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       mgmt_act;
  logic       user_act;
  logic       sel_wp;
  logic       prefix_hit;
  logic       kill_now;

  assign mgmt_act = sel_mgmt_q & ~killed;
  assign user_act = sel_user_q & ~killed;
  assign active   = mgmt_act | user_act;
  assign wp_block = killed;

  // Gate enables only move on the falling edge, so ANDing with SCK cannot glitch.
  assign mgmt_flash_csb = ~mgmt_act;
  assign user_flash_csb = ~user_act;
  assign mgmt_flash_clk = SCK & mgmt_act;
  assign user_flash_clk = SCK & user_act;
  assign mgmt_flash_io0 = SDI & mgmt_act;
  assign user_flash_io0 = SDI & user_act;
  assign SDO = mgmt_act ? mgmt_flash_io1 : (user_act ? user_flash_io1 : slave_sdo);

  assign sel_wp     = (sel_mgmt_q & wp_mgmt) | (sel_user_q & wp_user);
  assign prefix_hit = (shift == WP_PREFIX0) || (shift == WP_PREFIX1);
  assign kill_now   = active && (byte_cnt == 8'd0) && (bit_cnt == 3'd7) && sel_wp && prefix_hit;

  always_ff @(negedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      sel_mgmt_q <= 1'b0;
      sel_user_q <= 1'b0;
      killed     <= 1'b0;
    end else begin
      // Target locks once per transaction; mgmt wins a tie.
      if (!sel_mgmt_q && !sel_user_q) begin
        if (pt_mgmt_sel)
          sel_mgmt_q <= 1'b1;
        else if (pt_user_sel)
          sel_user_q <= 1'b1;
      end
      if (kill_now)
        killed <= 1'b1;
    end
  end

  // Counting keeps running after a kill so cmd_byte and byte_cnt still reflect the host stream.
  always_ff @(posedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      shift    <= 7'd0;
      cmd_byte <= 8'd0;
    end else if (sel_mgmt_q || sel_user_q) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= {shift[5:0], SDI};
      if (bit_cnt == 3'd7) begin
        if (byte_cnt != 8'hff)
          byte_cnt <= byte_cnt + 8'd1;
        if (byte_cnt == 8'd0)
          cmd_byte <= {shift, SDI};
      end
    end
  end

endmodule

// File: tb/tb_hk_flash_passthru_ctrl.sv
// tb/tb_hk_flash_passthru_ctrl.sv - randomized bench for hk_flash_passthru_ctrl against a transaction-level model
module tb_hk_flash_passthru_ctrl;

  logic       SCK = 1'b0;
  logic       csb_reset = 1'b1;
  logic       SDI = 1'b0;
  logic       slave_sdo = 1'b0;
  logic       pt_mgmt_sel = 1'b0;
  logic       pt_user_sel = 1'b0;
  logic       wp_mgmt = 1'b0;
  logic       wp_user = 1'b0;
  logic       mgmt_flash_io1 = 1'b0;
  logic       user_flash_io1 = 1'b0;
  logic       SDO;
  logic       mgmt_flash_csb, user_flash_csb;
  logic       mgmt_flash_clk, user_flash_clk;
  logic       mgmt_flash_io0, user_flash_io0;
  logic       active;
  logic [7:0] cmd_byte;
  logic [7:0] byte_cnt;
  logic       wp_block;

  int vectors = 0;
  int errors  = 0;
  int mclk_n  = 0;
  int uclk_n  = 0;
  logic [7:0] tx[$];
  logic [7:0] rsp[$];

  hk_flash_passthru_ctrl dut (
    .SCK(SCK), .csb_reset(csb_reset), .SDI(SDI), .slave_sdo(slave_sdo), .SDO(SDO),
    .pt_mgmt_sel(pt_mgmt_sel), .pt_user_sel(pt_user_sel), .wp_mgmt(wp_mgmt), .wp_user(wp_user),
    .mgmt_flash_csb(mgmt_flash_csb), .user_flash_csb(user_flash_csb),
    .mgmt_flash_clk(mgmt_flash_clk), .user_flash_clk(user_flash_clk),
    .mgmt_flash_io0(mgmt_flash_io0), .user_flash_io0(user_flash_io0),
    .mgmt_flash_io1(mgmt_flash_io1), .user_flash_io1(user_flash_io1),
    .active(active), .cmd_byte(cmd_byte), .byte_cnt(byte_cnt), .wp_block(wp_block)
  );

  always @(posedge mgmt_flash_clk) mclk_n++;
  always @(posedge user_flash_clk) uclk_n++;

  task automatic fill(input int n);
    tx.delete();
    rsp.delete();
    for (int i = 0; i < n; i++) begin
      tx.push_back(8'($urandom));
      rsp.push_back(8'($urandom));
    end
  endtask

  // One pass-through transaction: a preamble SCK pulse locks the target, then nbits host bits.
  // abort_at > 0 raises CSB while SCK is high after that many bits.
  task automatic run_txn(input bit pre_m, input bit pre_u, input bit wm, input bit wu,
                         input int nbits, input int abort_at, input string tag);
    bit   tgt_user, wp_t, blocked, exp_act, r, io0, exp_sdo;
    int   pulses, exp_cnt;
    logic [7:0] exp_cmd;
    logic [5:0] got, expv;
    tgt_user = !pre_m;
    wp_t     = tgt_user ? wu : wm;
    blocked  = wp_t && (tx[0][7:1] == 7'h03 || tx[0][7:1] == 7'h28) && nbits >= 7;
    wp_mgmt = wm; wp_user = wu;
    SCK = 0; csb_reset = 1;
    #5 csb_reset = 0;
    mclk_n = 0; uclk_n = 0;
    pt_mgmt_sel = pre_m; pt_user_sel = pre_u; SDI = 1'($urandom);
    #5 SCK = 1;
    #5 SCK = 0;
    #2;
    vectors++;
    if (mgmt_flash_csb !== tgt_user || user_flash_csb !== !tgt_user) begin
      errors++;
      $display("FAIL %s lock: csb m/u=%b%b required %b%b", tag, mgmt_flash_csb, user_flash_csb, tgt_user, !tgt_user);
    end
    #3;
    for (int n = 0; n < nbits; n++) begin
      exp_act = !(blocked && n >= 7);
      SDI = tx[n / 8][7 - (n % 8)];
      r   = rsp[n / 8][7 - (n % 8)];
      if (tgt_user) begin user_flash_io1 = r; mgmt_flash_io1 = 1'($urandom); end
      else          begin mgmt_flash_io1 = r; user_flash_io1 = 1'($urandom); end
      slave_sdo   = 1'($urandom);
      pt_mgmt_sel = 1'($urandom);
      pt_user_sel = 1'($urandom);
      #2;
      exp_sdo = exp_act ? r : slave_sdo;
      io0     = exp_act & SDI;
      got  = {SDO, mgmt_flash_csb, user_flash_csb, mgmt_flash_io0, user_flash_io0, active};
      expv = {exp_sdo, tgt_user ? 1'b1 : !exp_act, tgt_user ? !exp_act : 1'b1,
              tgt_user ? 1'b0 : io0, tgt_user ? io0 : 1'b0, exp_act};
      vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s bit%0d pins{sdo,mcsb,ucsb,mio0,uio0,act}: got %b required %b", tag, n, got, expv);
      end
      #3 SCK = 1;
      #2;
      vectors++;
      if (mgmt_flash_clk !== (exp_act && !tgt_user) || user_flash_clk !== (exp_act && tgt_user)) begin
        errors++;
        $display("FAIL %s bit%0d clk m/u: got %b%b required %b%b", tag, n, mgmt_flash_clk, user_flash_clk,
                 exp_act && !tgt_user, exp_act && tgt_user);
      end
      if (n == abort_at - 1) begin
        csb_reset = 1;
        #1;
        vectors++;
        if ({mgmt_flash_csb, user_flash_csb, mgmt_flash_clk, user_flash_clk, mgmt_flash_io0, user_flash_io0, active, wp_block} !== 8'b11000000
            || cmd_byte !== 8'h00 || byte_cnt !== 8'h00 || SDO !== slave_sdo) begin
          errors++;
          $display("FAIL %s abort: csb=%b%b clk=%b%b io0=%b%b act=%b wpb=%b cmd=%h cnt=%0d sdo=%b required csb=11 clk=00 io0=00 act=0 wpb=0 cmd=00 cnt=0 sdo=%b",
                   tag, mgmt_flash_csb, user_flash_csb, mgmt_flash_clk, user_flash_clk, mgmt_flash_io0, user_flash_io0,
                   active, wp_block, cmd_byte, byte_cnt, SDO, slave_sdo);
        end
        #2 SCK = 0;
        #5;
        return;
      end
      #3 SCK = 0;
      #5;
    end
    pulses  = blocked ? 7 : nbits;
    exp_cnt = (nbits / 8 > 255) ? 255 : nbits / 8;
    exp_cmd = (nbits >= 8) ? tx[0] : 8'h00;
    vectors++;
    if ((tgt_user ? uclk_n : mclk_n) !== pulses || (tgt_user ? mclk_n : uclk_n) !== 0) begin
      errors++;
      $display("FAIL %s pulses: mgmt=%0d user=%0d required target=%0d other=0", tag, mclk_n, uclk_n, pulses);
    end
    vectors++;
    if (cmd_byte !== exp_cmd || byte_cnt !== 8'(exp_cnt) || wp_block !== blocked) begin
      errors++;
      $display("FAIL %s summary: cmd=%h cnt=%0d wpb=%b required cmd=%h cnt=%0d wpb=%b",
               tag, cmd_byte, byte_cnt, wp_block, exp_cmd, exp_cnt, blocked);
    end
  endtask

  task automatic test_reset();
    csb_reset = 1;
    for (int i = 0; i < 12; i++) begin
      SCK = 1'($urandom); pt_mgmt_sel = 1'($urandom); pt_user_sel = 1'($urandom);
      slave_sdo = 1'($urandom); SDI = 1'($urandom);
      #2;
      vectors++;
      if ({mgmt_flash_csb, user_flash_csb, mgmt_flash_clk, user_flash_clk, mgmt_flash_io0, user_flash_io0, active, wp_block} !== 8'b11000000
          || cmd_byte !== 8'h00 || byte_cnt !== 8'h00 || SDO !== slave_sdo) begin
        errors++;
        $display("FAIL reset%0d: csb=%b%b clk=%b%b io0=%b%b act=%b wpb=%b cmd=%h cnt=%0d sdo=%b required 11 00 00 0 0 00 0 sdo=%b",
                 i, mgmt_flash_csb, user_flash_csb, mgmt_flash_clk, user_flash_clk, mgmt_flash_io0, user_flash_io0,
                 active, wp_block, cmd_byte, byte_cnt, SDO, slave_sdo);
      end
      #3;
    end
    SCK = 0;
  endtask

  task automatic test_mgmt_read();
    fill(6);
    tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h10; tx[3] = 8'h00;
    rsp[4] = 8'hA5; rsp[5] = 8'h5A;
    run_txn(1, 0, 0, 1'($urandom), 48, 0, "mgmt_read");
  endtask

  task automatic test_wp_block();
    fill(2);
    tx[0] = 8'h06; tx[1] = 8'h02;
    run_txn(1, 0, 1, 0, 16, 0, "wp_block_06");
    fill(2);
    tx[0] = 8'h50;
    run_txn(1, 0, 1, 0, 16, 0, "wp_block_50");
    fill(2);
    tx[0] = 8'h51;
    run_txn(0, 1, 0, 1, 16, 0, "wp_block_user_51");
  endtask

  task automatic test_wp_pass();
    fill(1);
    tx[0] = 8'h05;
    run_txn(0, 1, 0, 1, 8, 0, "wp_pass_05");
    fill(1);
    tx[0] = 8'h06;
    run_txn(0, 1, 1, 0, 8, 0, "wp_pass_unprot");
  endtask

  task automatic test_arbitration_lock();
    fill(3);
    run_txn(1, 1, 0, 0, 24, 0, "arb_both");
  endtask

  task automatic test_random();
    logic [7:0] firsts[5];
    bit pm;
    firsts[0] = 8'h06; firsts[1] = 8'h07; firsts[2] = 8'h50; firsts[3] = 8'h51; firsts[4] = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      fill(5);
      tx[0] = firsts[$urandom_range(0, 4)];
      pm = 1'($urandom);
      run_txn(pm, !pm || 1'($urandom), 1'($urandom), 1'($urandom),
              8 * $urandom_range(1, 4) + $urandom_range(0, 7), 0, "random");
    end
  endtask

  task automatic test_saturation();
    fill(300);
    tx[0] = 8'h0B;
    run_txn(1, 0, 0, 0, 2400, 0, "saturate");
  endtask

  task automatic test_abort();
    fill(2);
    run_txn(1, 0, 0, 0, 12, 12, "abort_mgmt");
    fill(2);
    run_txn(0, 1, 0, 0, 11, 11, "abort_user");
  endtask

  initial begin
    test_reset();
    test_mgmt_read();
    test_wp_block();
    test_wp_pass();
    test_arbitration_lock();
    test_random();
    test_saturation();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
